// File: rtl/piso_tx_32bit.sv
// piso_tx_32bit
//
// Parallel-in/serial-out transmitter. A WIDTH-bit word is taken over a
// valid/ready load handshake while idle, then drained one bit per accepted
// serial beat onto a 1-bit link. After the last beat is accepted, frame_done
// pulses for a single cycle before the block returns to idle.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   LSB_FIRST  1: bit 0 goes out first; 0: bit WIDTH-1 goes out first
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   load_valid   load_data holds a word to transmit
//   load_ready   block can accept a word (idle only)
//   load_data    parallel word, sampled only on the accepting edge
//   ser_ready    sink accepts the presented serial bit this cycle
//   ser_valid    ser_out carries a valid bit
//   ser_out      serial data bit
//   frame_start  high while the first bit of a word is presented
//   frame_done   one-cycle pulse after the last bit is accepted
//   busy         a word is in flight (shifting or finishing)
//   bit_count    bits already accepted in the current word

module piso_tx_32bit #(
    parameter int WIDTH     = 32,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [WIDTH-1:0]           load_data,
    input  logic                       ser_ready,
    output logic                       ser_valid,
    output logic                       ser_out,
    output logic                       frame_start,
    output logic                       frame_done,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_count
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL_WORD = CW'(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;

    // Next-state logic. The word is captured only on the accepting edge in
    // idle, and the shift register only moves on an accepted beat, so a
    // stall of any length simply holds everything in place.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    shift_d = load_data;
                    count_d = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ser_ready) begin
                    // Zero fill means the register is all zeros once drained.
                    if (LSB_FIRST) begin
                        shift_d = shift_q >> 1;
                    end else begin
                        shift_d = shift_q << 1;
                    end
                    if (count_q == LAST_BIT) begin
                        count_d = FULL_WORD;
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            ST_DONE: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    // All outputs decode registered state only; nothing passes combinationally
    // from the inputs to the outputs.
    always_comb begin
        load_ready  = (state_q == ST_IDLE);
        ser_valid   = (state_q == ST_SHIFT);
        busy        = (state_q == ST_SHIFT) || (state_q == ST_DONE);
        frame_done  = (state_q == ST_DONE);
        frame_start = (state_q == ST_SHIFT) && (count_q == '0);
        bit_count   = count_q;
        if (state_q == ST_SHIFT) begin
            ser_out = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];
        end else begin
            ser_out = 1'b0;
        end
    end

endmodule

// File: tb/tb_piso_tx_32bit.sv
// tb_piso_tx_32bit
//
// Bench for piso_tx_32bit. Two instances share all inputs: one transmits
// LSB first, the other MSB first. A word-level reference model (word held,
// number of beats accepted, finishing flag) predicts every output of both
// instances each cycle; directed table entries and hand-written sequences
// cover stalls, ignored loads, back-to-back words and mid-word reset.

module tb_piso_tx_32bit;

    localparam int WIDTH = 32;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clock = 1'b0;
    logic             reset;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             ser_ready;

    logic          load_ready_l, ser_valid_l, ser_out_l, frame_start_l, frame_done_l, busy_l;
    logic [CW-1:0] bit_count_l;
    logic          load_ready_m, ser_valid_m, ser_out_m, frame_start_m, frame_done_m, busy_m;
    logic [CW-1:0] bit_count_m;

    piso_tx_32bit #(.WIDTH(WIDTH), .LSB_FIRST(1'b1)) dut_lsb (
        .clock(clock), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready_l), .load_data(load_data),
        .ser_ready(ser_ready), .ser_valid(ser_valid_l), .ser_out(ser_out_l),
        .frame_start(frame_start_l), .frame_done(frame_done_l),
        .busy(busy_l), .bit_count(bit_count_l)
    );

    piso_tx_32bit #(.WIDTH(WIDTH), .LSB_FIRST(1'b0)) dut_msb (
        .clock(clock), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready_m), .load_data(load_data),
        .ser_ready(ser_ready), .ser_valid(ser_valid_m), .ser_out(ser_out_m),
        .frame_start(frame_start_m), .frame_done(frame_done_m),
        .busy(busy_m), .bit_count(bit_count_m)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: the word in flight, how many of its bits the sink has
    // taken, and whether the post-word finishing cycle is current.
    logic [WIDTH-1:0] m_word;
    int               m_k;
    logic             m_in_flight;
    logic             m_done;

    typedef struct {
        logic [WIDTH-1:0] word;
        int               stall_beat;
        int               stall_len;
        int               exp_edges;
        logic             exp_lsb_first;
        logic             exp_lsb_last;
        logic             exp_msb_first;
        logic             exp_msb_last;
    } vec_t;

    vec_t vecs[5];

    function automatic void check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_word      = '0;
        m_k         = 0;
        m_in_flight = 1'b0;
        m_done      = 1'b0;
    endfunction

    function automatic void model_update();
        if (!reset) begin
            model_reset();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_in_flight) begin
            if (ser_ready) begin
                m_k++;
                if (m_k == WIDTH) begin
                    m_in_flight = 1'b0;
                    m_done      = 1'b1;
                end
            end
        end else if (load_valid) begin
            m_word      = load_data;
            m_k         = 0;
            m_in_flight = 1'b1;
        end
    endfunction

    function automatic logic model_bit(input bit lsb_first);
        if (!m_in_flight) return 1'b0;
        return lsb_first ? m_word[m_k] : m_word[WIDTH-1-m_k];
    endfunction

    task automatic checkOutput();
        logic          exp_ready, exp_busy, exp_start;
        logic [CW-1:0] exp_count;
        exp_ready = !m_in_flight && !m_done;
        exp_busy  = m_in_flight || m_done;
        exp_start = m_in_flight && (m_k == 0);
        exp_count = m_in_flight ? CW'(m_k) : (m_done ? CW'(WIDTH) : '0);
        check_val("lsb.load_ready",  load_ready_l,  exp_ready);
        check_val("lsb.ser_valid",   ser_valid_l,   m_in_flight);
        check_val("lsb.ser_out",     ser_out_l,     model_bit(1'b1));
        check_val("lsb.frame_start", frame_start_l, exp_start);
        check_val("lsb.frame_done",  frame_done_l,  m_done);
        check_val("lsb.busy",        busy_l,        exp_busy);
        check_val("lsb.bit_count",   bit_count_l,   exp_count);
        check_val("msb.load_ready",  load_ready_m,  exp_ready);
        check_val("msb.ser_valid",   ser_valid_m,   m_in_flight);
        check_val("msb.ser_out",     ser_out_m,     model_bit(1'b0));
        check_val("msb.frame_start", frame_start_m, exp_start);
        check_val("msb.frame_done",  frame_done_m,  m_done);
        check_val("msb.busy",        busy_m,        exp_busy);
        check_val("msb.bit_count",   bit_count_m,   exp_count);
    endtask

    task automatic applyStimulus(input logic lv, input logic [WIDTH-1:0] data, input logic sr);
        load_valid = lv;
        load_data  = data;
        ser_ready  = sr;
    endtask

    // Compare the settled outputs, then advance one clock with the model.
    task automatic tick();
        checkOutput();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    // Send one word, optionally stalling the sink on one beat, and record
    // the first and last bit each instance presented.
    task automatic run_word(input vec_t v, output int edges,
                            output logic lf, output logic ll, output logic mf, output logic ml);
        int   stall_left;
        logic sr;
        lf = 1'bx; ll = 1'bx; mf = 1'bx; ml = 1'bx;
        applyStimulus(1'b1, v.word, 1'b1);
        tick();
        edges      = 1;
        stall_left = v.stall_len;
        while (!frame_done_l && edges < 100) begin
            sr = 1'b1;
            if (m_in_flight && m_k == v.stall_beat && stall_left > 0) begin
                sr = 1'b0;
                stall_left--;
            end
            applyStimulus(1'b0, $urandom, sr);
            if (ser_valid_l && bit_count_l == 0)            lf = ser_out_l;
            if (ser_valid_l && bit_count_l == CW'(WIDTH-1)) ll = ser_out_l;
            if (ser_valid_m && bit_count_m == 0)            mf = ser_out_m;
            if (ser_valid_m && bit_count_m == CW'(WIDTH-1)) ml = ser_out_m;
            tick();
            edges++;
        end
        applyStimulus(1'b0, $urandom, 1'b1);
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   edges;
        logic lf, ll, mf, ml;

        vecs[0] = '{32'hA5A5_0F0F, -1, 0, 33, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{32'h8000_0001, -1, 0, 33, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{32'h0000_00FF,  5, 3, 36, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{32'h0000_0001,  0, 2, 35, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{32'hFFFF_FFFE, 31, 4, 37, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset state, asserted before any clock edge.
        reset = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        model_reset();
        #1;
        checkOutput();
        @(negedge clock);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Directed words, including stalls on the first, a middle and the last beat.
        for (int i = 0; i < 5; i++) begin
            run_word(vecs[i], edges, lf, ll, mf, ml);
            check_val($sformatf("vec%0d.done_edges", i), edges, vecs[i].exp_edges);
            check_val($sformatf("vec%0d.lsb_first", i), lf, vecs[i].exp_lsb_first);
            check_val($sformatf("vec%0d.lsb_last", i),  ll, vecs[i].exp_lsb_last);
            check_val($sformatf("vec%0d.msb_first", i), mf, vecs[i].exp_msb_first);
            check_val($sformatf("vec%0d.msb_last", i),  ml, vecs[i].exp_msb_last);
        end

        // load_valid held high with changing data while busy: ignored until the
        // first idle cycle, giving a 34-cycle back-to-back period.
        applyStimulus(1'b1, 32'h1357_9BDF, 1'b1);
        tick();
        edges = 0;
        begin
            logic gap;
            gap = 1'b0;
            while (edges < 100) begin
                if (gap && frame_start_l) break;
                if (!frame_start_l) gap = 1'b1;
                applyStimulus(1'b1, $urandom, 1'b1);
                tick();
                edges++;
            end
        end
        check_val("b2b.period", edges, 34);
        edges = 0;
        while (!frame_done_l && edges < 100) begin
            applyStimulus(1'b0, $urandom, 1'b1);
            tick();
            edges++;
        end
        check_val("b2b.second_done", frame_done_l, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        tick();

        // Reset at beat 17 aborts the word immediately, without frame_done.
        applyStimulus(1'b1, 32'h1234_5678, 1'b1);
        tick();
        edges = 0;
        while (bit_count_l != 17 && edges < 100) begin
            applyStimulus(1'b0, $urandom, 1'b1);
            tick();
            edges++;
        end
        check_val("abort.reached_beat17", bit_count_l, 17);
        reset = 1'b0;
        model_reset();
        #1;
        checkOutput();
        check_val("abort.frame_done", frame_done_l, 1'b0);
        check_val("abort.load_ready", load_ready_l, 1'b1);
        @(negedge clock);
        // Reset released with load_valid already high: captured on the first edge.
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_val("release.frame_start", frame_start_l, 1'b1);
        check_val("release.bit_count", bit_count_l, 0);
        edges = 1;
        while (!frame_done_l && edges < 100) begin
            applyStimulus(1'b0, $urandom, 1'b1);
            tick();
            edges++;
        end
        check_val("release.done_edges", edges, 33);
        applyStimulus(1'b0, '0, 1'b1);
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            applyStimulus($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 9) < 7);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b1);
        for (int c = 0; c < 40; c++) begin
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
